// File: rtl/uart_veri_receiver_core.sv
// 8N1 UART receiver: 2-flop synchronised rx_in, mid-bit sampling, one-entry valid/ack byte buffer, sticky framing/overrun flags.
// Optional even-parity bit and parity_err output under UART_VERI_RX_PARITY_EN; rx_valid rises 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT edges after the start edge.
module uart_veri_receiver_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
`ifdef UART_VERI_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_VERI_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             cnt_clr;
    logic             shift_en;
    logic             stop_smp;
    logic             deliver;
`ifdef UART_VERI_RX_PARITY_EN
    logic             par_smp;
`endif

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
`ifdef UART_VERI_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
`ifdef UART_VERI_RX_PARITY_EN
                    if (idx == 3'd7) state_nxt = PARITY;
`else
                    if (idx == 3'd7) state_nxt = STOP;
`endif
                end
            end
`ifdef UART_VERI_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_clr   = 1'b1;
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_clr   = 1'b1;
                    stop_smp  = 1'b1;
                    state_nxt = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // Line held low (break): wait for it to return high before re-arming.
                cnt_clr = 1'b1;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign deliver = stop_smp && rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
            idx         <= 3'd0;
            shreg       <= 8'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_VERI_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            cnt   <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state != DATA) idx <= 3'd0;
            else if (shift_en) idx <= idx + 3'd1;
            // LSB arrives first, so shifting in at the MSB leaves it in bit 0.
            if (shift_en) shreg <= {rx_s, shreg[7:1]};

            if (deliver && (!rx_valid || rx_ack)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            frame_err   <= (frame_err && !err_clr) || (stop_smp && !rx_s);
            overrun_err <= (overrun_err && !err_clr) || (deliver && rx_valid && !rx_ack);
`ifdef UART_VERI_RX_PARITY_EN
            parity_err  <= (parity_err && !err_clr) || (par_smp && (^shreg ^ rx_s));
`endif
        end
    end

endmodule

// File: tb/tb_uart_veri_receiver_core.sv
// Bench for uart_veri_receiver_core: directed frames plus random traffic, checked every cycle against a frame-level model.
module tb_uart_veri_receiver_core;

    localparam int CPB = 16;
`ifdef UART_VERI_RX_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam int LAT_LIT  = 170;
`else
    localparam int PAR_BITS = 0;
    localparam int LAT_LIT  = 154;
`endif
    localparam int STOP_OFS = 2 + CPB / 2 + (9 + PAR_BITS) * CPB;
    localparam int PAR_OFS  = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_VERI_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_veri_receiver_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_in),
        .rx_ack(rx_ack),
        .err_clr(err_clr),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .overrun_err(overrun_err),
        .busy(busy)
`ifdef UART_VERI_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] d;
        bit         ok;
        bit         p;
    } ev_t;
    typedef struct {
        int at;
        bit bad;
    } pev_t;

    ev_t        stop_q[$];
    pev_t       par_q[$];
    ev_t        ev;
    pev_t       pev;
    logic [7:0] got[$];

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_e0 = 0;
    int         rise_cyc = 0;
    bit         s_ack, s_clr, s_rst;
    bit         rand_on = 0;
    logic       prev_v = 1'b0;

    logic       m_v = 1'b0;
    logic [7:0] m_d = 8'h00;
    logic       m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;
    bit         dlv, nfe, nov, npe;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Capture what the DUT sees at each active edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        s_ack = rx_ack;
        s_clr = err_clr;
        s_rst = rst;
    end

    // Frame-level model advanced once per edge, then compared on the falling edge.
    initial forever begin
        @(negedge clk);
        if (s_rst) begin
            m_v = 1'b0; m_d = 8'h00; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
            stop_q.delete();
            par_q.delete();
        end else begin
            dlv = 0; nfe = 0; nov = 0; npe = 0;
            if (stop_q.size() > 0 && stop_q[0].at == cyc) begin
                ev = stop_q.pop_front();
                if (ev.ok) begin
                    if (!m_v || s_ack) begin
                        m_d = ev.d;
                        dlv = 1;
                    end else begin
                        nov = 1;
                    end
                end else begin
                    nfe = 1;
                end
            end
            if (par_q.size() > 0 && par_q[0].at == cyc) begin
                pev = par_q.pop_front();
                npe = pev.bad;
            end
            if (dlv) m_v = 1'b1;
            else if (s_ack) m_v = 1'b0;
            if (s_clr) begin
                m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
            end
            m_fe = m_fe | nfe;
            m_ov = m_ov | nov;
            m_pe = m_pe | npe;
        end
        chk("rx_valid", rx_valid, m_v);
        chk("rx_data", rx_data, m_d);
        chk("frame_err", frame_err, m_fe);
        chk("overrun_err", overrun_err, m_ov);
`ifdef UART_VERI_RX_PARITY_EN
        chk("parity_err", parity_err, m_pe);
`endif
        if (rx_valid === 1'b1 && prev_v !== 1'b1) begin
            rise_cyc = cyc;
            got.push_back(rx_data);
        end
        prev_v = rx_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Random ack/err_clr traffic during the random phase.
    initial begin
        wait (rand_on);
        while (rand_on) begin
            @(posedge clk);
            #1;
            rx_ack  = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
        end
        rx_ack  = 1'b0;
        err_clr = 1'b0;
    end

    task automatic bit_hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_v, input int low_bits);
        int e0;
        e0 = cyc + 1;
        last_e0 = e0;
        stop_q.push_back('{e0 + STOP_OFS, d, stop_v, par_v});
`ifdef UART_VERI_RX_PARITY_EN
        par_q.push_back('{e0 + PAR_OFS, (^d) ^ par_v});
`endif
        bit_hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_hold(d[i], CPB);
`ifdef UART_VERI_RX_PARITY_EN
        bit_hold(par_v, CPB);
`endif
        if (stop_v) bit_hold(1'b1, CPB);
        else bit_hold(1'b0, low_bits * CPB);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic ack_helper(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (rx_valid !== 1'b1 && t < 600) begin
                @(negedge clk);
                t++;
            end
            chk("ack_wait_valid", rx_valid, 1'b1);
            @(posedge clk);
            #1;
            rx_ack = 1'b1;
            @(posedge clk);
            #1;
            rx_ack = 1'b0;
        end
    endtask

    initial begin
        int n;
        logic [7:0] d;
        logic [7:0] c4;
        bit ok;
        bit p;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_flags", {frame_err, overrun_err}, 2'b00);
        bit_hold(1'b1, 4);

        // Single byte, latency pinned to a literal edge count.
        send_frame(8'h55, 1, 1'b0, 0);
        chk("t1_latency", rise_cyc - last_e0, LAT_LIT);
        chk("t1_data", rx_data, 8'h55);
        chk("t1_valid", rx_valid, 1'b1);
        chk("t1_flags", {frame_err, overrun_err}, 2'b00);
        chk("t1_busy", busy, 1'b0);
        pulse_ack();

        // Back-to-back frames, each acked.
        got.delete();
        fork
            begin
                send_frame(8'hA3, 1, 1'b0, 0);
                send_frame(8'h3C, 1, 1'b0, 0);
            end
            ack_helper(2);
        join
        chk("t2_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_first", got[0], 8'hA3);
            chk("t2_second", got[1], 8'h3C);
        end
        chk("t2_overrun", overrun_err, 1'b0);

        // Overrun: second byte dropped, first kept.
        send_frame(8'h11, 1, 1'b0, 0);
        send_frame(8'h22, 1, 1'b0, 0);
        chk("t3_data", rx_data, 8'h11);
        chk("t3_valid", rx_valid, 1'b1);
        chk("t3_overrun", overrun_err, 1'b1);
        pulse_clr();
        chk("t3_cleared", overrun_err, 1'b0);
        pulse_ack();

        // Framing error with a long break, then recovery.
        send_frame(8'h7E, 0, 1'b0, 40);
        chk("t4_frame_err", frame_err, 1'b1);
        chk("t4_valid", rx_valid, 1'b0);
        chk("t4_busy_low_line", busy, 1'b1);
        bit_hold(1'b1, CPB);
        chk("t4_busy_released", busy, 1'b0);
        send_frame(8'h81, 1, 1'b0, 0);
        chk("t4_next_data", rx_data, 8'h81);
        chk("t4_next_valid", rx_valid, 1'b1);
        pulse_ack();

        // Short glitch must not start a frame.
        n = got.size();
        bit_hold(1'b0, 3);
        bit_hold(1'b1, 30);
        chk("t5_glitch_busy", busy, 1'b0);
        chk("t5_glitch_valid", rx_valid, 1'b0);
        chk("t5_glitch_nobyte", got.size(), n);
        chk("t5_glitch_frame_err", frame_err, 1'b1);

        // Reset mid-frame with a byte pending and a sticky flag set.
        send_frame(8'h5A, 1, 1'b0, 0);
        c4 = 8'hC4;
        bit_hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_hold(c4[i], CPB);
        rx_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_rst_valid", rx_valid, 1'b0);
        chk("t5_rst_data", rx_data, 8'h00);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_flags", {frame_err, overrun_err}, 2'b00);
        bit_hold(1'b1, CPB);
        send_frame(8'hC4, 1, 1'b0, 0);
        chk("t5_after_rst", rx_data, 8'hC4);
        pulse_ack();

`ifdef UART_VERI_RX_PARITY_EN
        send_frame(8'h07, 1, 1'b0, 0);
        chk("t6_par_data", rx_data, 8'h07);
        chk("t6_par_valid", rx_valid, 1'b1);
        chk("t6_par_err", parity_err, 1'b1);
        pulse_ack();
        send_frame(8'h03, 1, 1'b0, 0);
        chk("t6_par_sticky", parity_err, 1'b1);
        chk("t6_par_data2", rx_data, 8'h03);
        pulse_clr();
        chk("t6_par_cleared", parity_err, 1'b0);
        pulse_ack();
`endif

        // Random traffic.
        rand_on = 1;
        for (int f = 0; f < 40; f++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            p  = (^d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, ok, p, 1);
            if (!ok) bit_hold(1'b1, CPB + $urandom_range(0, CPB));
            else if ($urandom_range(0, 1) == 1) bit_hold(1'b1, $urandom_range(1, 2 * CPB));
        end
        rand_on = 0;
        bit_hold(1'b1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_veri_receiver_core.md
Name: uart_veri_receiver_core

Overview:
- Serial UART receiver for the Verilator simulation flow; the receiving end of the 8N1 stream produced by the core's debug/console UART transmitter.
- Oversamples rx_in, reassembles bytes LSB-first and holds each byte in a one-entry buffer with a valid/ack handshake.
- The C++ testbench or the debug-frame decoder consumes bytes from that buffer. Error flags are exposed for framing and overrun.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; even, minimum 4.
- CNT_W, $clog2(CLKS_PER_BIT)+1, bit-period counter width; derived, do not override.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous reset, active-high.
- rx_in  input  1  serial line, idle high, asynchronous to clk.
- rx_ack  input  1  consumer accepts the held byte; sampled every cycle.
- err_clr  input  1  clears sticky error flags.
- rx_data  output  8  held byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun_err  output  1  sticky; byte completed while buffer full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1 at clk edge): FSM=IDLE; sync flops=1; rx_data=8'h00; rx_valid=0; frame_err=0; overrun_err=0; busy=0. Reset mid-frame abandons the frame with no flag.
- Input path: 2-flop synchronizer, reset value 1. The FSM uses only the second flop (rx_s).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Counter cnt and bit index idx[2:0].
- IDLE: if rx_s==0, go to START with cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA with cnt=0, idx=0. If 1, it is a glitch: return to IDLE, no flag.
- DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shreg MSB so the first bit ends in bit0, and reset cnt. Increment idx; after idx==7, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1: deliver the byte and go to IDLE.
  - If 0: set frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE (break handling).
- Delivery, evaluated in the stop-sample cycle:
  - If rx_valid==0, or rx_ack==1 in the same cycle: rx_data<=byte, rx_valid<=1 next cycle.
  - Otherwise: overrun_err<=1; the new byte is dropped and the old byte is kept.
- rx_ack with no delivery: rx_valid<=0 next cycle. rx_ack while rx_valid==0 is ignored. rx_data is unchanged by ack.
- err_clr clears both flags next cycle. If err_clr coincides with a new error, the error wins and the flag stays 1.
- busy = (state != IDLE), registered with state.
- Latency: let E0 be the first clk edge at which the first sync flop captures the start-bit 0. rx_valid is observed high after edge E0 + 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT. That is 154 edges for CLKS_PER_BIT=16.
- Back-to-back frames are accepted. The stop-bit sample occurs at mid-bit, so the next start edge is detected in IDLE.

Optional Feature:
- Macro UART_VERI_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the 8 data bits, sampled by a PARITY state (same timing as a DATA bit) between DATA and STOP.
  - Extra output parity_err (1 bit, sticky, cleared by err_clr, reset 0). It is set when the XOR of data and parity bit is 1.
  - A byte with bad parity is still delivered if the stop bit is good.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity_err port; frame is 8N1.

Test Plan:
- Reset, then drive 0x55 8N1 at 16 clks/bit with rx_ack tied 0 → rx_valid rises at E0+154, rx_data=8'h55, no flags, busy low afterwards.
- Send 0xA3 and 0x3C back-to-back; pulse rx_ack one cycle after each rx_valid → two deliveries, 0xA3 then 0x3C; overrun_err=0.
- Send 0x11 and 0x22 with no ack → rx_data stays 8'h11, overrun_err=1. Pulse err_clr → overrun_err=0.
- Send 0x7E with the stop bit forced 0, holding the line low 40 bits → frame_err=1, rx_valid=0, busy=1 until the line returns high. The next frame 0x81 is delivered correctly.
- Drive a 3-clk low glitch on rx_in → FSM returns to IDLE, no rx_valid, no flags. Assert rst mid-frame after 4 data bits → all outputs at reset values next cycle; the next full frame 0xC4 is received correctly.
- With UART_VERI_RX_PARITY_EN defined, send 0x07 with parity 0 → rx_data=8'h07, rx_valid=1, parity_err=1. Send 0x03 with parity 0 → parity_err stays 1 until err_clr.
